// File: rtl/data_mem_responder.sv
// data_mem_responder: target side of the MEM-stage load/store interface.
// Accepts one word-aligned request, waits LATENCY edges, and then presents
// the load data or the error status until the requester takes it.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        busy_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t        state;
    logic [CW-1:0] cnt;
    req_t          held;
    req_t          in_req;
    req_t          cm;
    logic          cm_err;
    logic [AW-1:0] cm_idx;
    logic          accept;
    logic          commit;
    logic [31:0]   rd_val;
    logic [31:0]   mem [DEPTH_WORDS];

    // Request capture mux: a LATENCY==1 build commits straight from the ports
    // at the accept edge, every other commit uses the registered copy.
    always_comb begin
        in_req = '{write: req_write_i, addr: req_addr_i, wdata: req_wdata_i};
        cm     = (state == IDLE) ? in_req : held;
        // Range check covers all of addr[31:2] so nothing beyond the array
        // can alias back onto a low index.
        cm_err = (cm.addr[1:0] != 2'b00) || (|cm.addr[31:AW+2]);
        cm_idx = cm.addr[AW+1:2];
        accept = req_valid_i && req_ready_o;
        commit = rst_i && (((state == IDLE) && accept && (LATENCY == 1)) ||
                           ((state == WAIT) && (cnt == CW'(1))));
        rd_val = (cm.write || cm_err) ? 32'h0 : mem[cm_idx];
    end

    assign req_ready_o = (state == IDLE) && rst_i;
    assign busy_o      = (state != IDLE);

    // Backing store; contents survive reset, and a reset on the commit edge
    // suppresses the write through the rst_i term in commit.
    always_ff @(posedge clk_i) begin
        if (commit && cm.write && !cm_err) mem[cm_idx] <= cm.wdata;
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= 32'h0;
            resp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        held <= in_req;
                        cnt  <= CW'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_rdata_o <= rd_val;
                            resp_err_o   <= cm_err;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state        <= RESP;
                        resp_valid_o <= 1'b1;
                        resp_rdata_o <= rd_val;
                        resp_err_o   <= cm_err;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state        <= IDLE;
                        resp_valid_o <= 1'b0;
                        resp_rdata_o <= 32'h0;
                        resp_err_o   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder: the target side of the load/store interface driven by the pipeline's MEM stage.
- Accepts one word-aligned read or write request over a valid/ready handshake and waits a fixed access latency.
- Returns read data and error status over a second valid/ready handshake.
- Replaces the single-cycle data store when modelling slow memory. Backing store is a word array inside the block.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the backing store (power of two, >= 2)
LATENCY, 3, clock edges from request acceptance to resp_valid_o rising (>= 1)

Ports:
clk_i  input  1  single clock, rising edge
rst_i  input  1  reset, synchronous, active-low
req_valid_i  input  1  request present
req_ready_o  output  1  block can accept request this cycle
req_write_i  input  1  1 = store, 0 = load
req_addr_i  input  32  byte address
req_wdata_i  input  32  store data
resp_valid_o  output  1  response present
resp_ready_i  input  1  requester takes response this cycle
resp_rdata_o  output  32  load data (0 for stores and errors)
resp_err_o  output  1  misaligned or out-of-range request
busy_o  output  1  request accepted and response not yet taken

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-low. All state updates occur on the rising edge of clk_i.
- Reset (rst_i=0 at an edge):
  - state=IDLE, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, busy_o=0, latency counter=0.
  - req_ready_o is 0 whenever rst_i=0.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - req_ready_o = (state==IDLE) && rst_i.
  - busy_o = (state!=IDLE).
- IDLE:
  - Accept on req_valid_i && req_ready_o.
  - On acceptance, register write, addr and wdata; set cnt=LATENCY-1.
  - Go to WAIT if LATENCY>1; go directly to RESP (commit performed at this edge) if LATENCY==1.
- WAIT:
  - Decrement cnt each edge.
  - At the edge where cnt==1, commit and move to RESP.
  - The request is accepted at edge N; resp_valid_o is first high in the cycle after edge N+LATENCY-1, i.e. exactly LATENCY edges after acceptance.
- Commit (single edge):
  - err = (addr[1:0]!=0) || (addr[31:2] >= DEPTH_WORDS).
  - Write && !err: mem[addr[31:2]] <= wdata; resp_rdata_o <= 0.
  - Read && !err: resp_rdata_o <= mem[addr[31:2]] (value before any same-edge write; none is possible since there is one outstanding request).
  - err: no array write; resp_rdata_o <= 0; resp_err_o <= 1.
  - resp_valid_o <= 1.
- RESP:
  - resp_valid_o, resp_rdata_o and resp_err_o are held stable until resp_ready_i=1 at an edge.
  - At that edge: resp_valid_o <= 0, resp_err_o <= 0, resp_rdata_o <= 0, state <= IDLE.
- Request interface rules:
  - A new request cannot be accepted in the same cycle as a response handshake. Minimum spacing between acceptances is LATENCY+1 edges.
  - req_* inputs are ignored outside IDLE; changes to them during WAIT/RESP have no effect on the in-flight operation.
  - Response is only ever presented after a completed commit.
- Reset mid-operation:
  - Reset in WAIT aborts the operation with no array write.
  - Reset in RESP drops the pending response; a store committed at an earlier edge stays written.
  - Reset coincident with the commit edge takes priority: no write.
- resp_ready_i high while resp_valid_o=0 has no effect.
- Index uses addr[log2(DEPTH_WORDS)+1:2]. Out-of-range is checked on the full addr[31:2], so no aliasing/wrap-around.

Test Plan:
- Reset: hold rst_i=0 for 2 edges with req_valid_i=1 -> req_ready_o=0, resp_valid_o=0, busy_o=0. After release, req_ready_o=1 and nothing is accepted until then.
- Write/read, LATENCY=3: store 0xDEADBEEF to 0x10, resp_ready_i=1 -> resp_valid_o high exactly 3 edges after accept, err=0, rdata=0. Load 0x10 -> rdata=0xDEADBEEF, err=0.
- Backpressure: load with resp_ready_i=0 for 5 cycles -> resp_valid_o and rdata held constant, req_ready_o=0. Raise resp_ready_i -> idle next cycle, then accepts next request.
- Errors: store to 0x13 -> err=1, rdata=0, mem[4] unchanged. Load from 0x400 with DEPTH_WORDS=256 -> err=1, rdata=0. Store to 0x3FC succeeds.
- Reset mid-op: accept store 0x55 to 0x20, assert rst_i=0 at the edge after accept -> load 0x20 afterwards returns the prior value. Also check req_* toggling during WAIT does not alter the in-flight result.
- LATENCY=1 build: accept at edge N -> resp_valid_o=1 after edge N. Back-to-back requests with resp_ready_i=1 are accepted every 2 edges.
